key_counter_bank: RTL and testbench
===================================

Name: key_counter_bank

Overview:
- Parametrised bank of N_CH independent up/down counters, each driven by a pair of active-low push-buttons.
- Each button input gets a two-flop synchroniser, a debounce filter and press-edge detection.
- Optional per-channel free-run mode counts up on a shared prescaler tick; counters wrap or saturate at the limits.
- Sits between the board key/sw pins and the led/hex display logic of the lab top level.

Parameters:
- N_CH, 2, number of counter channels.
- WIDTH, 5, bits per counter.
- DB_CYCLES, 500000, consecutive stable cycles needed to accept a key change (10 ms at 50 MHz); minimum value 1.
- DIV_W, 22, prescaler width; the free-run tick fires once every 2**DIV_W cycles.
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits.

Ports:
- clk  input  1  system clock (max10_clk1_50).
- reset  input  1  synchronous, active-high reset.
- key_up_n  input  N_CH  raw asynchronous button, active low; a press increments channel i.
- key_dn_n  input  N_CH  raw asynchronous button, active low; a press decrements channel i.
- free_run  input  N_CH  level; high enables prescaler-tick increments on channel i.
- clr  input  N_CH  synchronous clear of channel i, level-sensitive.
- cnt  output  N_CH*WIDTH  packed counter values; channel i occupies bits [i*WIDTH +: WIDTH].
- limit  output  N_CH  one-cycle pulse when channel i wraps, or when an attempted step is blocked by saturation.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the flops sample it on posedge clk.
- State on reset:
  - Synchroniser flops = 1 and debounced state = 1 (released).
  - Debounce counters = 0, prescaler = 0.
  - cnt = 0, limit = 0.
- Synchroniser: two flops per key; the second-stage output is the filter input s.
- Debounce, per key:
  - Counter dc increments each cycle that s != db_state and clears to 0 on any cycle where s == db_state.
  - When s != db_state and dc == DB_CYCLES-1, db_state <= s and dc <= 0 at that edge.
- Press event = db_state flipping 1->0; this acts on cnt at the same edge. Release (0->1) has no effect.
- Latency: key low first sampled at edge k; cnt shows the new value after edge k+1+DB_CYCLES.
- Glitches shorter than DB_CYCLES produce no event.
- Prescaler: free-running DIV_W-bit counter. tick = 1 for one cycle when the prescaler equals all-ones.
- Per-channel update, in priority order:
  1. reset: everything to reset values.
  2. clr[i]: cnt_i <= 0, limit_i <= 0; key events and tick are discarded that cycle. Debounce state still updates, so a press that completes during clr is lost.
  3. Up event and down event together: no change.
  4. Up event alone: +1.
  5. Down event alone: -1.
  6. No key event, free_run[i] = 1 and tick = 1: +1.
  - A key event in the same cycle as a tick suppresses the tick for that channel.
- Arithmetic is WIDTH-bit unsigned.
- SATURATE=0:
  - max +1 -> 0 and 0 -1 -> max.
  - limit_i pulses at the edge where the wrap is registered.
- SATURATE=1:
  - +1 at max, or -1 at 0, leaves cnt unchanged.
  - limit_i pulses for that cycle.
- limit is registered: high for exactly one cycle after the causing edge, otherwise 0.
- Key held low through reset: after reset deasserts, db_state = 1, so the held key is accepted as a new press DB_CYCLES+2 edges later.
- Channels are fully independent apart from the shared prescaler.

Decomposition:
- Shared header constants in config.vh:
  - default DB_CYCLES for 50 MHz.
  - simulation overrides: DB_CYCLES=4, DIV_W=3.
  - the derived debounce counter width, $clog2(DB_CYCLES).
- Sub-module key_debounce (one instance per key, 2*N_CH total):
  - Ports: clk, reset, key_n, pressed.
  - Contains the synchroniser, dc, db_state and the press-edge output.
- The top level holds the prescaler and a generate loop of per-channel counter logic.

Test Plan (DB_CYCLES=4, WIDTH=4, DIV_W=3, N_CH=2, SATURATE=0 unless stated):
- Reset, then key_up_n[0] low from edge 10 and held -> cnt[3:0] goes 0->1 after edge 15, no further change while held; cnt[7:4] stays 0.
- Pulse key_up_n[0] low for 3 cycles -> no change, limit stays 0.
- Channel 0 at 15 (4'hF), one up press -> cnt 0, limit[0] high for exactly 1 cycle. Same with SATURATE=1 -> cnt stays 15, limit[0] pulses.
- Channel 1 at 0: down press -> 15 with limit[1] pulse. Then up and down keys pressed in the same cycle -> stays 15, no limit.
- free_run[0]=1 for 64 cycles from reset -> cnt[3:0] = 8. An up press landing on a tick cycle adds only 1.
- Channel 0 at 7: assert clr[0] for 1 cycle -> 0. Assert reset while key_dn_n[1] held low -> all outputs 0, then channel 1 decrements to 15 at the 6th edge after reset deasserts.

Source files
------------

// File: rtl/key_counter_bank_pkg.sv
// Shared constants, types and helpers for the key-driven counter bank.
package key_counter_bank_pkg;

    localparam int unsigned DEF_N_CH        = 2;
    localparam int unsigned DEF_WIDTH       = 5;
    localparam int unsigned DB_CYCLES_50MHZ = 500000;   // 10 ms of stable key at 50 MHz
    localparam int unsigned DEF_DIV_W       = 22;

    // Short timings for simulation so debounce and free-run fit in a few hundred cycles.
    localparam int unsigned SIM_DB_CYCLES   = 4;
    localparam int unsigned SIM_DIV_W       = 3;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_e;

    // Debounce counter width; never below one bit so DB_CYCLES = 1 stays legal.
    function automatic int unsigned dc_width(input int unsigned db_cycles);
        return (db_cycles > 1) ? $clog2(db_cycles) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, stability filter and press-edge detect.
module key_debounce
    import key_counter_bank_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_50MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed
);

    localparam int unsigned          DC_W    = dc_width(DB_CYCLES);
    localparam logic [DC_W-1:0]      DC_LAST = DC_W'(DB_CYCLES - 1);

    logic            sync_q1;
    logic            sync_q2;
    logic            db_state;
    logic [DC_W-1:0] dc;
    logic            differs;
    logic            settle;

    assign differs = (sync_q2 != db_state);
    assign settle  = differs && (dc == DC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            db_state <= 1'b1;
            dc       <= '0;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
            if (!differs) begin
                dc <= '0;
            end else if (settle) begin
                db_state <= sync_q2;
                dc       <= '0;
            end else begin
                dc <= dc + DC_W'(1);
            end
        end
    end

    // Asserted in the cycle the filtered state is about to flip released -> pressed,
    // so the counter acts on the same edge that accepts the press.
    assign pressed = settle & db_state & ~sync_q2;

endmodule

// File: rtl/key_counter_bank.sv
// Bank of independent up/down counters fed by debounced key pairs, with optional
// free-running increment from a shared prescaler.
module key_counter_bank
    import key_counter_bank_pkg::*;
#(
    parameter int unsigned N_CH      = DEF_N_CH,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DB_CYCLES = DB_CYCLES_50MHZ,
    parameter int unsigned DIV_W     = DEF_DIV_W,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       key_up_n,
    input  logic [N_CH-1:0]       key_dn_n,
    input  logic [N_CH-1:0]       free_run,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH*WIDTH-1:0] cnt,
    output logic [N_CH-1:0]       limit
);

    logic [DIV_W-1:0] presc;
    logic             tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else begin
            presc <= presc + DIV_W'(1);
        end
    end

    assign tick = &presc;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        logic             up_ev;
        logic             dn_ev;
        step_e            step;
        logic [WIDTH-1:0] cnt_q;
        logic             lim_q;
        logic             at_max;
        logic             at_min;

        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_up (
            .clk     (clk),
            .reset   (reset),
            .key_n   (key_up_n[i]),
            .pressed (up_ev)
        );

        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_dn (
            .clk     (clk),
            .reset   (reset),
            .key_n   (key_dn_n[i]),
            .pressed (dn_ev)
        );

        // Any key event, including a cancelling up+down pair, masks the free-run tick.
        always_comb begin
            step = STEP_NONE;
            if (up_ev && !dn_ev) begin
                step = STEP_UP;
            end else if (dn_ev && !up_ev) begin
                step = STEP_DN;
            end else if (!up_ev && !dn_ev && free_run[i] && tick) begin
                step = STEP_UP;
            end
        end

        assign at_max = (cnt_q == {WIDTH{1'b1}});
        assign at_min = (cnt_q == '0);

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
                lim_q <= 1'b0;
            end else if (clr[i]) begin
                cnt_q <= '0;
                lim_q <= 1'b0;
            end else begin
                lim_q <= 1'b0;
                unique case (step)
                    STEP_UP: begin
                        if (at_max) begin
                            lim_q <= 1'b1;
                            if (!SATURATE) cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + WIDTH'(1);
                        end
                    end
                    STEP_DN: begin
                        if (at_min) begin
                            lim_q <= 1'b1;
                            if (!SATURATE) cnt_q <= {WIDTH{1'b1}};
                        end else begin
                            cnt_q <= cnt_q - WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign cnt[i*WIDTH +: WIDTH] = cnt_q;
        assign limit[i]              = lim_q;
    end

endmodule

// File: tb/tb_key_counter_bank.sv
// Bench for key_counter_bank: a wrapping and a saturating instance share stimulus;
// expected values are queued with their due edge and checked when that edge passes.
module tb_key_counter_bank;
    import key_counter_bank_pkg::*;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned DIV_W = SIM_DIV_W;
    localparam int          DB    = int'(SIM_DB_CYCLES);

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] key_up_n = 2'b11;
    logic [1:0] key_dn_n = 2'b11;
    logic [1:0] free_run = 2'b00;
    logic [1:0] clr      = 2'b00;
    logic [7:0] cnt_w;
    logic [7:0] cnt_s;
    logic [1:0] lim_w;
    logic [1:0] lim_s;

    key_counter_bank #(
        .N_CH (N_CH), .WIDTH (WIDTH), .DB_CYCLES (SIM_DB_CYCLES),
        .DIV_W (DIV_W), .SATURATE (1'b0)
    ) dut_w (
        .clk (clk), .reset (reset), .key_up_n (key_up_n), .key_dn_n (key_dn_n),
        .free_run (free_run), .clr (clr), .cnt (cnt_w), .limit (lim_w)
    );

    key_counter_bank #(
        .N_CH (N_CH), .WIDTH (WIDTH), .DB_CYCLES (SIM_DB_CYCLES),
        .DIV_W (DIV_W), .SATURATE (1'b1)
    ) dut_s (
        .clk (clk), .reset (reset), .key_up_n (key_up_n), .key_dn_n (key_dn_n),
        .free_run (free_run), .clr (clr), .cnt (cnt_s), .limit (lim_s)
    );

    always #5 clk = ~clk;

    int edge_count = 0;
    always @(posedge clk) edge_count <= edge_count + 1;

    typedef struct {
        int         due;
        bit         sat;
        logic [7:0] cnt;
        logic [1:0] lim;
        string      name;
    } sb_t;

    typedef struct {
        logic [1:0] up;
        logic [1:0] dn;
        logic [7:0] exp_w;
        logic [1:0] lim_w;
        logic [7:0] exp_s;
        logic [1:0] lim_s;
    } row_t;

    sb_t  sb[$];
    row_t rows[19];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void expect_at(input string name, input int due,
                                      input logic [7:0] cw, input logic [1:0] lw,
                                      input logic [7:0] cs, input logic [1:0] ls);
        sb.push_back('{due, 1'b0, cw, lw, name});
        sb.push_back('{due, 1'b1, cs, ls, name});
    endfunction

    // Check every queued expectation whose edge has arrived.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= edge_count) begin
                logic [7:0] ac;
                logic [1:0] al;
                ac = sb[i].sat ? cnt_s : cnt_w;
                al = sb[i].sat ? lim_s : lim_w;
                n_cmp = n_cmp + 1;
                if (sb[i].due != edge_count || ac !== sb[i].cnt || al !== sb[i].lim) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s %s edge %0d (due %0d): cnt=%h limit=%b, expected cnt=%h limit=%b",
                             sb[i].name, sb[i].sat ? "sat" : "wrap", edge_count, sb[i].due,
                             ac, al, sb[i].cnt, sb[i].lim);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press the keys of one row, hold them well past acceptance, then release and settle.
    task automatic press_row(input row_t r, input logic [7:0] pw, input logic [7:0] ps,
                             input string name);
        int e;
        e = edge_count;
        key_up_n = ~r.up;
        key_dn_n = ~r.dn;
        expect_at($sformatf("%s before", name), e + DB + 1, pw, 2'b00, ps, 2'b00);
        expect_at($sformatf("%s event", name),  e + DB + 2, r.exp_w, r.lim_w, r.exp_s, r.lim_s);
        expect_at($sformatf("%s after", name),  e + DB + 3, r.exp_w, 2'b00, r.exp_s, 2'b00);
        expect_at($sformatf("%s held", name),   e + DB + 6, r.exp_w, 2'b00, r.exp_s, 2'b00);
        step(DB + 6);
        key_up_n = 2'b11;
        key_dn_n = 2'b11;
        step(DB + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pw;
        logic [7:0] ps;
        int e;
        int r;

        rows[0]  = '{2'b00, 2'b10, 8'hF0, 2'b10, 8'h00, 2'b10};
        rows[1]  = '{2'b10, 2'b10, 8'hF0, 2'b00, 8'h00, 2'b00};
        for (int i = 0; i < 15; i++) begin
            rows[2 + i] = '{2'b01, 2'b00, {4'hF, 4'(i + 1)}, 2'b00, {4'h0, 4'(i + 1)}, 2'b00};
        end
        rows[17] = '{2'b01, 2'b00, 8'hF0, 2'b01, 8'h0F, 2'b01};
        rows[18] = '{2'b10, 2'b00, 8'h00, 2'b10, 8'h1F, 2'b00};

        step(3);
        expect_at("reset", edge_count + 1, 8'h00, 2'b00, 8'h00, 2'b00);
        step(1);
        reset = 1'b0;
        step(2);

        pw = 8'h00;
        ps = 8'h00;
        for (int i = 0; i < 19; i++) begin
            press_row(rows[i], pw, ps, $sformatf("row%0d", i));
            pw = rows[i].exp_w;
            ps = rows[i].exp_s;
        end

        // Glitch shorter than the debounce window.
        e = edge_count;
        key_up_n = 2'b10;
        expect_at("glitch a", e + DB + 2, pw, 2'b00, ps, 2'b00);
        expect_at("glitch b", e + DB + 4, pw, 2'b00, ps, 2'b00);
        expect_at("glitch c", e + 12,     pw, 2'b00, ps, 2'b00);
        step(3);
        key_up_n = 2'b11;
        step(12);

        // Free-run from reset, then a press landing on a tick cycle.
        reset = 1'b1;
        expect_at("reset2", edge_count + 1, 8'h00, 2'b00, 8'h00, 2'b00);
        step(2);
        reset    = 1'b0;
        free_run = 2'b01;
        r = edge_count;
        expect_at("freerun 63", r + 63, 8'h07, 2'b00, 8'h07, 2'b00);
        expect_at("freerun 64", r + 64, 8'h08, 2'b00, 8'h08, 2'b00);
        step(66);
        key_up_n = 2'b10;
        expect_at("tick+press before", r + 71, 8'h08, 2'b00, 8'h08, 2'b00);
        expect_at("tick+press",        r + 72, 8'h09, 2'b00, 8'h09, 2'b00);
        expect_at("tick+press hold",   r + 79, 8'h09, 2'b00, 8'h09, 2'b00);
        expect_at("next tick",         r + 80, 8'h0A, 2'b00, 8'h0A, 2'b00);
        step(8);
        key_up_n = 2'b11;
        step(6);
        free_run = 2'b00;
        step(2);

        // Single-cycle clear.
        e = edge_count;
        clr = 2'b01;
        expect_at("clr before", e,     8'h0A, 2'b00, 8'h0A, 2'b00);
        expect_at("clr",        e + 1, 8'h00, 2'b00, 8'h00, 2'b00);
        expect_at("clr after",  e + 3, 8'h00, 2'b00, 8'h00, 2'b00);
        step(1);
        clr = 2'b00;
        step(3);

        // Reset while a down key is held: the held key is taken as a fresh press.
        key_dn_n = 2'b01;
        step(20);
        reset = 1'b1;
        expect_at("reset3", edge_count + 1, 8'h00, 2'b00, 8'h00, 2'b00);
        step(3);
        reset = 1'b0;
        r = edge_count;
        expect_at("held dn before", r + 5, 8'h00, 2'b00, 8'h00, 2'b00);
        expect_at("held dn event",  r + 6, 8'hF0, 2'b10, 8'h00, 2'b10);
        expect_at("held dn after",  r + 7, 8'hF0, 2'b00, 8'h00, 2'b00);
        step(8);
        key_dn_n = 2'b11;
        step(10);

        while (sb.size() > 0) begin
            sb_t x;
            x = sb.pop_front();
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s %s: check due at edge %0d never evaluated (now %0d)",
                     x.name, x.sat ? "sat" : "wrap", x.due, edge_count);
        end

        // Final quiescent state of both instances.
        n_cmp = n_cmp + 1;
        if (cnt_w !== 8'hF0) begin
            n_bad = n_bad + 1;
            $display("FAIL final wrap cnt=%h expected F0", cnt_w);
        end
        n_cmp = n_cmp + 1;
        if (cnt_s !== 8'h00) begin
            n_bad = n_bad + 1;
            $display("FAIL final sat cnt=%h expected 00", cnt_s);
        end
        n_cmp = n_cmp + 1;
        if (lim_w !== 2'b00) begin
            n_bad = n_bad + 1;
            $display("FAIL final wrap limit=%b expected 00", lim_w);
        end
        n_cmp = n_cmp + 1;
        if (lim_s !== 2'b00) begin
            n_bad = n_bad + 1;
            $display("FAIL final sat limit=%b expected 00", lim_s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
